// File: rtl/button_event.sv
//============================================================================
// Module      : button_event
// Description : Turns a debounced, clk-synchronous, active-high button level
//               into one-cycle event pulses. The events are press, release,
//               single click, double click and long press. An optional
//               auto-repeat pulse is available while the button is long-held.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   btn_in       in   debounced button level (synchronous to clk)
//   press_p      out  pulse on each rising edge of btn_in
//   release_p    out  pulse on each falling edge of btn_in
//   click_p      out  pulse for a completed short single click
//   dbl_click_p  out  pulse for a completed double click
//   long_p       out  pulse when a press reaches LONG_CNT high samples
//   repeat_p     out  auto-repeat pulse while long-held (optional feature)
//   busy         out  high whenever the classifier FSM is not idle
//----------------------------------------------------------------------------
// Build option
//   BUTTON_EVENT_REPEAT_EN : when defined, repeat_p pulses every REPEAT_CNT
//                            cycles while the button stays long-held. When
//                            undefined, repeat_p is tied low.
//============================================================================
`default_nettype none

module button_event #(
  parameter int LONG_CNT   = 16,
  parameter int DBL_GAP    = 8,
  parameter int REPEAT_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic press_p,
  output logic release_p,
  output logic click_p,
  output logic dbl_click_p,
  output logic long_p,
  output logic repeat_p,
  output logic busy
);

  localparam int HOLD_W = $clog2(LONG_CNT + 1);
  localparam int GAP_W  = $clog2(DBL_GAP + 1);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CNT);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(DBL_GAP);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRESS1    = 3'd1;
  localparam logic [2:0] GAP       = 3'd2;
  localparam logic [2:0] PRESS2    = 3'd3;
  localparam logic [2:0] LONG_HELD = 3'd4;

  // Elaboration-time guard on the legal parameter ranges.
  if (LONG_CNT < 2 || DBL_GAP < 2 || REPEAT_CNT < 1) begin : g_param_check
    $error("button_event: illegal parameter value");
  end

  logic              btn_q;
  logic [2:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              press_q, release_q;
  logic              click_q, click_d;
  logic              dbl_q, dbl_d;
  logic              long_q, long_d;

  logic              w_rise;
  logic              w_fall;
  logic [HOLD_W-1:0] w_hold_inc;
  logic [GAP_W-1:0]  w_gap_inc;

  assign w_rise = btn_in & ~btn_q;
  assign w_fall = ~btn_in & btn_q;

  // Saturating increments. The FSM leaves each counting state before the
  // limit can be exceeded, so saturation only guards against wrap.
  assign w_hold_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
  assign w_gap_inc  = (gap_cnt_q == GAP_MAX) ? gap_cnt_q : gap_cnt_q + GAP_W'(1);

  // Classification FSM. The sample that causes entry into a counting state
  // is itself the first counted sample, so each counter is loaded with 1.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    click_d    = 1'b0;
    dbl_d      = 1'b0;
    long_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_rise) begin
          hold_cnt_d = HOLD_W'(1);
          state_d    = PRESS1;
        end
      end
      PRESS1, PRESS2: begin
        if (btn_in) begin
          hold_cnt_d = w_hold_inc;
          if (w_hold_inc == HOLD_MAX) begin
            long_d  = 1'b1;
            state_d = LONG_HELD;
          end
        end else if (state_q == PRESS1) begin
          gap_cnt_d = GAP_W'(1);
          state_d   = GAP;
        end else begin
          dbl_d   = 1'b1;
          state_d = IDLE;
        end
      end
      GAP: begin
        // btn_q is always low in GAP, so a high sample is a rise; checking it
        // first makes a rise win over a simultaneous gap expiry.
        if (btn_in) begin
          hold_cnt_d = HOLD_W'(1);
          state_d    = PRESS2;
        end else begin
          gap_cnt_d = w_gap_inc;
          if (w_gap_inc == GAP_MAX) begin
            click_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      LONG_HELD: begin
        if (!btn_in) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q      <= 1'b0;
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      click_q    <= 1'b0;
      dbl_q      <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      btn_q      <= btn_in;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      press_q    <= w_rise;
      release_q  <= w_fall;
      click_q    <= click_d;
      dbl_q      <= dbl_d;
      long_q     <= long_d;
    end
  end

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CNT + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CNT);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [REP_W-1:0] w_rep_inc;
  logic             repeat_q, repeat_d;

  assign w_rep_inc = rep_cnt_q + REP_W'(1);

  // The counter sits at zero outside LONG_HELD. It is therefore zero on
  // entry, and the first pulse lands REPEAT_CNT cycles after long_p.
  always_comb begin
    rep_cnt_d = '0;
    repeat_d  = 1'b0;
    if (state_q == LONG_HELD && btn_in) begin
      if (w_rep_inc == REP_MAX) begin
        repeat_d = 1'b1;
      end else begin
        rep_cnt_d = w_rep_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign repeat_p = repeat_q;
`else
  assign repeat_p = 1'b0;
`endif

  assign press_p     = press_q;
  assign release_p   = release_q;
  assign click_p     = click_q;
  assign dbl_click_p = dbl_q;
  assign long_p      = long_q;
  assign busy        = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_button_event.sv
//============================================================================
// Module      : tb_button_event
// Description : Directed self-checking bench for button_event
//               (LONG_CNT=8, DBL_GAP=6, REPEAT_CNT=4).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_button_event;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_in;
  logic press_p, release_p, click_p, dbl_click_p, long_p, repeat_p, busy;

  button_event #(
    .LONG_CNT  (8),
    .DBL_GAP   (6),
    .REPEAT_CNT(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .press_p    (press_p),
    .release_p  (release_p),
    .click_p    (click_p),
    .dbl_click_p(dbl_click_p),
    .long_p     (long_p),
    .repeat_p   (repeat_p),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // cyc equals k between rising edge k and edge k+1, so a pulse seen at the
  // following falling edge is attributed to the sample taken at edge k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_press = 0, n_rel = 0, n_click = 0, n_dbl = 0, n_long = 0, n_rep = 0, n_excl = 0;
  int at_press = -1, at_rel = -1, at_click = -1, at_dbl = -1, at_long = -1;
  int at_rep_first = -1, at_rep_last = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (press_p)     begin n_press <= n_press + 1; at_press <= cyc; end
      if (release_p)   begin n_rel   <= n_rel + 1;   at_rel   <= cyc; end
      if (click_p)     begin n_click <= n_click + 1; at_click <= cyc; end
      if (dbl_click_p) begin n_dbl   <= n_dbl + 1;   at_dbl   <= cyc; end
      if (long_p)      begin n_long  <= n_long + 1;  at_long  <= cyc; end
      if (repeat_p) begin
        n_rep       <= n_rep + 1;
        at_rep_last <= cyc;
        if (at_rep_first < 0 || at_rep_first < at_long) at_rep_first <= cyc;
      end
      if ((int'(click_p) + int'(dbl_click_p) + int'(long_p)) > 1) n_excl <= n_excl + 1;
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int b_press, b_rel, b_click, b_dbl, b_long, b_rep;
  int t, t2;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    repeat (n) begin
      btn_in = lvl;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    b_press = n_press; b_rel = n_rel; b_click = n_click;
    b_dbl = n_dbl; b_long = n_long; b_rep = n_rep;
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_outs"}, int'({press_p, release_p, click_p, dbl_click_p, long_p, repeat_p}), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    btn_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_low("reset");
    rst_n = 1'b1;
    drive(1'b0, 3);

    // Single click: high 3, low 10.
    snap(); t = cyc + 1;
    drive(1'b1, 3);
    drive(1'b0, 10);
    chk("s1_press_n", n_press - b_press, 1);
    chk("s1_press_at", at_press, t);
    chk("s1_rel_at", at_rel, t + 3);
    chk("s1_click_n", n_click - b_click, 1);
    chk("s1_click_at", at_click, t + 8);
    chk("s1_dbl_long_n", (n_dbl - b_dbl) + (n_long - b_long), 0);
    chk("s1_busy", int'(busy), 0);

    // Double click: high 3, low 4, high 3, low.
    snap(); t = cyc + 1;
    drive(1'b1, 3);
    drive(1'b0, 4);
    drive(1'b1, 3);
    drive(1'b0, 8);
    chk("s2_press_n", n_press - b_press, 2);
    chk("s2_press_at", at_press, t + 7);
    chk("s2_rel_at", at_rel, t + 10);
    chk("s2_dbl_n", n_dbl - b_dbl, 1);
    chk("s2_dbl_at", at_dbl, t + 10);
    chk("s2_click_n", n_click - b_click, 0);
    chk("s2_busy", int'(busy), 0);

    // Long press: high 20.
    snap(); t = cyc + 1;
    drive(1'b1, 20);
    drive(1'b0, 8);
    chk("s3_long_n", n_long - b_long, 1);
    chk("s3_long_at", at_long, t + 7);
    chk("s3_rel_n", n_rel - b_rel, 1);
    chk("s3_rel_at", at_rel, t + 20);
    chk("s3_click_dbl_n", (n_click - b_click) + (n_dbl - b_dbl), 0);
`ifdef BUTTON_EVENT_REPEAT_EN
    chk("s3_rep_n", n_rep - b_rep, 3);
    chk("s3_rep_first", at_rep_first, t + 11);
    chk("s3_rep_last", at_rep_last, t + 19);
`else
    chk("s3_rep_n", n_rep - b_rep, 0);
`endif

    // Gap boundary: 5 low samples, then rise -> PRESS2, no click.
    snap(); t = cyc + 1;
    drive(1'b1, 3);
    drive(1'b0, 5);
    drive(1'b1, 2);
    chk("s4a_busy_mid", int'(busy), 1);
    chk("s4a_click_mid", n_click - b_click, 0);
    drive(1'b0, 8);
    chk("s4a_dbl_n", n_dbl - b_dbl, 1);
    chk("s4a_dbl_at", at_dbl, t + 10);
    chk("s4a_click_n", n_click - b_click, 0);

    // Gap boundary: 6 low samples -> click, then the rise starts a fresh PRESS1.
    snap(); t = cyc + 1;
    drive(1'b1, 3);
    drive(1'b0, 6);
    drive(1'b1, 2);
    chk("s4b_click_mid", n_click - b_click, 1);
    chk("s4b_click_at", at_click, t + 8);
    chk("s4b_busy_mid", int'(busy), 1);
    drive(1'b0, 10);
    chk("s4b_click_n", n_click - b_click, 2);
    chk("s4b_click_at2", at_click, t + 16);
    chk("s4b_dbl_n", n_dbl - b_dbl, 0);
    chk("s4b_press_n", n_press - b_press, 2);

    // Second press long: high 3, low 2, high 10.
    snap(); t = cyc + 1;
    drive(1'b1, 3);
    drive(1'b0, 2);
    drive(1'b1, 10);
    drive(1'b0, 8);
    chk("s5_long_n", n_long - b_long, 1);
    chk("s5_long_at", at_long, t + 12);
    chk("s5_click_dbl_n", (n_click - b_click) + (n_dbl - b_dbl), 0);
    chk("s5_rep_n", n_rep - b_rep, 0);
    chk("s5_busy", int'(busy), 0);

    // Reset mid-press at hold_cnt=5, released with the button still high.
    drive(1'b1, 5);
    rst_n = 1'b0;
    #1;
    chk_all_low("s6_rst_a");
    @(posedge clk); #1;
    chk_all_low("s6_rst_b");
    @(posedge clk); #1;
    rst_n = 1'b1;
    snap(); t2 = cyc + 1;
    drive(1'b1, 10);
    drive(1'b0, 8);
    chk("s6_press_n", n_press - b_press, 1);
    chk("s6_press_at", at_press, t2);
    chk("s6_long_n", n_long - b_long, 1);
    chk("s6_long_at", at_long, t2 + 7);
    chk("s6_busy", int'(busy), 0);

    chk("excl_violations", n_excl, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
